beta_inv_seq: RTL
=================

Name: beta_inv_seq

Overview:
- Iterative inverse of the SWAN beta (S-box) layer, used on the decryption datapath.
- Takes one 32-bit half-block and substitutes its 4-bit columns through the inverse of the beta_table S-box, LANES columns per cycle.
- Valid/ready handshakes on both sides. The output word is held until the consumer accepts it.
- Sits between the decryption round-key mixing stage and the inverse theta/permutation stage.

Parameters:
- BLOCK_SIZE, 64, cipher block width in bits.
- SIDE_SIZE, BLOCK_SIZE/2, half-block width processed by this unit (32).
- COLUMN_SIZE, SIDE_SIZE/4, number of 4-bit columns per half-block (8).
- LANES, 1, columns substituted per cycle. Must divide COLUMN_SIZE; legal values are 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  x is valid.
- in_ready  output  1  unit can accept a word.
- x  input  [0:SIDE_SIZE-1]  beta-layer output to be inverted.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer accepts y.
- y  output  [0:SIDE_SIZE-1]  inverse-substituted word.
- busy  output  1  substitution in progress.

Behaviour:
- Reset: asynchronous, active-high.
  - On rst, state=IDLE, data register=0, column counter=0.
  - Outputs while in reset: in_ready=0, out_valid=0, busy=0, y=0.
  - in_ready rises in the first cycle after rst deasserts.
- Column layout (identical to beta_table): column j, for j=0..COLUMN_SIZE-1, is {x[j], x[j+8], x[j+16], x[j+24]}, with x[j] the S-box MSB. Inverse S-box output bits go back to the same positions.
- Inverse S-box: exact inverse of the 4-bit beta_table S-box, so beta_table(y) == x for every x. This implies S^-1(0x3)=0xF.
- Internal state: a data register, a column counter cnt of width clog2(COLUMN_SIZE/LANES), and a state machine.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load x into the data register, cnt=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, replace columns cnt*LANES .. cnt*LANES+LANES-1 in the register with their inverse S-box values, then increment cnt.
  - After the cycle in which cnt = COLUMN_SIZE/LANES-1 is processed, go to DONE.
- DONE:
  - out_valid=1, y=data register. y stays stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, out_valid=0.
- Latency:
  - Handshake in cycle T gives out_valid=1 from cycle T+1+COLUMN_SIZE/LANES: T+9 for LANES=1, T+2 for LANES=8.
  - Throughput is one word per COLUMN_SIZE/LANES+2 cycles.
- Boundary conditions:
  - in_valid while BUSY or DONE: ignored, x not sampled. The producer must hold its word until in_ready.
  - out_ready while not DONE: no effect.
  - out_ready asserted on the first DONE cycle: out_valid is high for exactly that one cycle.
  - Counter wrap-around cannot occur; cnt is cleared on every load.
  - rst mid-BUSY or mid-DONE: the in-flight word is discarded and out_valid drops immediately (asynchronous). No partial y is ever presented.
  - y while out_valid=0 is don't-care. The implementation drives the register contents; the bench must not check y unless out_valid=1.
- Purely synchronous datapath apart from rst. No combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
- Known vector 1, LANES=1: x=0xc8110af6 with in_valid=1 at cycle T, out_ready=1.
  - Required: out_valid first high at T+9 with y=0xc3ca1a12; busy high for 8 cycles.
- Known vector 2: x=0x0000ffff → y=0xffffffff.
  - Repeat with LANES=2, 4 and 8; out_valid must first be high at T+5, T+3 and T+2 respectively.
- Back-pressure: out_ready=0 for 20 cycles after out_valid rises.
  - y must hold 0xc3ca1a12 and in_ready stay 0 throughout.
  - A new in_valid word presented during this time is not taken.
  - Raise out_ready: one cycle later in_ready=1 and the waiting word is accepted.
- Reset mid-operation: assert rst for one half-cycle at cycle 4 of BUSY.
  - out_valid, busy and in_ready go to 0 at once; y=0.
  - The next accepted word 0x0000ffff produces 0xffffffff with normal latency.
- Round trip: for 1000 random 32-bit words r, feed beta_table(r) into this unit with random in_valid/out_ready gaps.
  - Every accepted output must equal r, in order, with no drops or duplicates.
  - Cover all 16 column values at every column position.

Source files
------------

// File: rtl/beta_inv_seq.sv
// beta_inv_seq: iterative inverse of the SWAN beta S-box layer on one half-block.
// LANES 4-bit columns are substituted per cycle behind valid/ready handshakes.
module beta_inv_seq #(
    parameter int BLOCK_SIZE  = 64,
    parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int LANES       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] y,
    output logic                 busy
);

    localparam int STEPS = COLUMN_SIZE / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = $clog2(SIDE_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [0:SIDE_SIZE-1]   data_r;
    logic [0:SIDE_SIZE-1]   data_nxt_s;
    logic [0:SIDE_SIZE-1]   subst_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [IDX_W-1:0]       base_s;
    logic [3:0]             nib_s;
    logic [3:0]             inv_s;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;

    // Inverse of beta_table {1,2,C,5,7,8,A,F,4,D,B,E,9,6,0,3}.
    function automatic logic [3:0] sbox_inv(input logic [3:0] v);
        case (v)
            4'h0:    sbox_inv = 4'hE;
            4'h1:    sbox_inv = 4'h0;
            4'h2:    sbox_inv = 4'h1;
            4'h3:    sbox_inv = 4'hF;
            4'h4:    sbox_inv = 4'h8;
            4'h5:    sbox_inv = 4'h3;
            4'h6:    sbox_inv = 4'hD;
            4'h7:    sbox_inv = 4'h4;
            4'h8:    sbox_inv = 4'h5;
            4'h9:    sbox_inv = 4'hC;
            4'hA:    sbox_inv = 4'h6;
            4'hB:    sbox_inv = 4'hA;
            4'hC:    sbox_inv = 4'h2;
            4'hD:    sbox_inv = 4'h9;
            4'hE:    sbox_inv = 4'hB;
            4'hF:    sbox_inv = 4'h7;
            default: sbox_inv = 4'h0;
        endcase
    endfunction

    // Substitute the columns selected by cnt_r; column j is {d[j], d[j+8], d[j+16], d[j+24]}.
    always_comb begin
        subst_s = data_r;
        base_s  = '0;
        nib_s   = 4'h0;
        inv_s   = 4'h0;
        for (int l = 0; l < LANES; l++) begin
            base_s = IDX_W'(cnt_r) * IDX_W'(LANES) + IDX_W'(l);
            nib_s  = {data_r[base_s],
                      data_r[base_s + IDX_W'(COLUMN_SIZE)],
                      data_r[base_s + IDX_W'(2 * COLUMN_SIZE)],
                      data_r[base_s + IDX_W'(3 * COLUMN_SIZE)]};
            inv_s  = sbox_inv(nib_s);
            subst_s[base_s]                             = inv_s[3];
            subst_s[base_s + IDX_W'(COLUMN_SIZE)]       = inv_s[2];
            subst_s[base_s + IDX_W'(2 * COLUMN_SIZE)]   = inv_s[1];
            subst_s[base_s + IDX_W'(3 * COLUMN_SIZE)]   = inv_s[0];
        end
    end

    // Next-state, next-data and counter logic for the IDLE/BUSY/DONE machine.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    data_nxt_s  = x;
                    cnt_nxt_s   = '0;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                data_nxt_s = subst_s;
                cnt_nxt_s  = cnt_r + 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Data, counter and handshake flags; flags come from the next state so outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r      <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            data_r      <= data_nxt_s;
            cnt_r       <= cnt_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s == BUSY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign y         = data_r;

endmodule
